// File: rtl/piece_bag_randomizer.sv
// piece_bag_randomizer: Galois-LFSR Tetris piece generator with 7-bag mode and preview queue
module piece_bag_randomizer #(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter int PREVIEW = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   seed_load,
  input  logic [LFSR_W-1:0]      seed,
  input  logic                   mode,
  input  logic                   take,
  output logic [2:0]             piece,
  output logic                   valid,
  output logic [3*PREVIEW-1:0]   preview,
  output logic [6:0]             bag_used
);
  localparam int Q = PREVIEW + 1;
  localparam int CW = $clog2(Q + 1);
  logic [LFSR_W-1:0] lfsr, lfsr_nx;
  logic [CW-1:0] count, cnt_pop, count_nx;
  logic [6:0] bag, bag_eff, bag_set, bag_nx;
  logic [2:0] q [Q];
  logic [2:0] q_nx [Q];
  logic [2:0] c;
  logic mode_r, pop, acc;
  always_comb begin
    pop = take && valid;
    cnt_pop = count - CW'(pop);
    c = lfsr[2:0];
    // a mode change wipes the bag in the same cycle the new mode is first seen
    bag_eff = (mode != mode_r || !mode) ? '0 : bag;
    acc = c != 3'd7 && cnt_pop < CW'(Q) && (!mode || !bag_eff[c]);
    bag_set = bag_eff | (acc ? 7'b1 << c : 7'b0);
    bag_nx = (!mode || bag_set == 7'h7F) ? '0 : bag_set;
    count_nx = cnt_pop + CW'(acc);
    lfsr_nx = seed_load ? (seed == '0 ? SEED : seed) : (lfsr[0] ? (lfsr >> 1) ^ TAPS : lfsr >> 1);
    for (int i = 0; i < Q; i++) q_nx[i] = q[i];
    if (pop) begin
      for (int i = 0; i < Q - 1; i++) q_nx[i] = q[i + 1];
      q_nx[Q-1] = '0;
    end
    for (int i = 0; i < Q; i++) if (acc && cnt_pop == CW'(i)) q_nx[i] = c;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
      count <= '0;
      bag <= '0;
      mode_r <= 1'b0;
      q <= '{default: '0};
    end else if (seed_load) begin
      lfsr <= lfsr_nx;
      count <= '0;
      bag <= '0;
      mode_r <= mode;
      q <= '{default: '0};
    end else begin
      lfsr <= lfsr_nx;
      count <= count_nx;
      bag <= bag_nx;
      mode_r <= mode;
      q <= q_nx;
    end
  end
  always_comb begin
    piece = q[0];
    valid = count == CW'(Q);
    bag_used = bag;
    for (int i = 1; i <= PREVIEW; i++) preview[3*(i-1) +: 3] = q[i];
  end
endmodule

// File: tb/tb_piece_bag_randomizer.sv
// tb_piece_bag_randomizer: randomized bench against a queue-based reference model
module tb_piece_bag_randomizer;
  localparam int Q = 4;
  logic clk = 0, reset = 1, seed_load = 0, mode = 0, take = 0;
  logic [15:0] seed = '0;
  logic [2:0] piece;
  logic valid;
  logic [8:0] preview;
  logic [6:0] bag_used;
  int passed = 0, total = 0;
  logic [15:0] m_lfsr;
  int mq[$];
  bit mbag[7];
  bit m_mode_prev;

  piece_bag_randomizer dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .mode(mode),
    .take(take), .piece(piece), .valid(valid), .preview(preview), .bag_used(bag_used)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    mq.delete();
    foreach (mbag[k]) mbag[k] = 0;
    m_mode_prev = 0;
  endtask

  task automatic model_step();
    int c;
    bit full;
    if (seed_load) begin
      m_lfsr = (seed == 0) ? 16'hACE1 : seed;
      mq.delete();
      foreach (mbag[k]) mbag[k] = 0;
    end else begin
      if (take && mq.size() == Q) void'(mq.pop_front());
      if (!mode || mode != m_mode_prev) foreach (mbag[k]) mbag[k] = 0;
      c = int'(m_lfsr[2:0]);
      if (c != 7 && mq.size() < Q && (!mode || !mbag[c])) begin
        mq.push_back(c);
        if (mode) begin
          mbag[c] = 1;
          full = 1;
          foreach (mbag[k]) if (!mbag[k]) full = 0;
          if (full) foreach (mbag[k]) mbag[k] = 0;
        end
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    m_mode_prev = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
  endtask

  function automatic logic [19:0] exp_out();
    logic [8:0] p;
    logic [6:0] b;
    p = '0;
    for (int i = 1; i < Q; i++) if (mq.size() > i) p[3*(i-1) +: 3] = 3'(mq[i]);
    foreach (mbag[k]) b[k] = mbag[k];
    return {mq.size() == Q, mq.size() > 0 ? 3'(mq[0]) : 3'd0, p, b};
  endfunction

  task automatic test_reset();
    reset = 1;
    model_reset();
    tick();
    tick();
    total++;
    if ({valid, piece, preview, bag_used} !== 20'h0) $display("FAIL reset_state got %h exp 00000", {valid, piece, preview, bag_used});
    else passed++;
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (valid !== 1'b0 || {valid, piece, preview, bag_used} !== exp_out()) $display("FAIL post_reset_cyc%0d got %h exp %h", i, {valid, piece, preview, bag_used}, exp_out());
      else passed++;
    end
    for (int i = 0; i < 40 && !valid; i++) tick();
    total++;
    if (valid !== 1'b1 || bag_used !== 7'h0 || {valid, piece, preview, bag_used} !== exp_out()) $display("FAIL reset_fill got %h exp %h", {valid, piece, preview, bag_used}, exp_out());
    else passed++;
  endtask

  task automatic test_seed_one();
    mode = 0;
    seed = 16'h0001;
    seed_load = 1;
    tick();
    seed_load = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({valid, piece, preview, bag_used} !== exp_out()) $display("FAIL seed1_cyc%0d got %h exp %h", i, {valid, piece, preview, bag_used}, exp_out());
      else passed++;
    end
    total++;
    if ({valid, piece, preview} !== {1'b1, 3'd1, 9'd0}) $display("FAIL seed1_const got %h exp %h", {valid, piece, preview}, {1'b1, 3'd1, 9'd0});
    else passed++;
  endtask

  task automatic test_bag_seed();
    mode = 1;
    seed = 16'h0001;
    seed_load = 1;
    tick();
    seed_load = 0;
    for (int i = 0; i < 30 && !valid; i++) begin
      tick();
      total++;
      if ({valid, piece, preview, bag_used} !== exp_out()) $display("FAIL bag_seed_cyc%0d got %h exp %h", i, {valid, piece, preview, bag_used}, exp_out());
      else passed++;
    end
    total++;
    if ({valid, piece, preview, bag_used} !== {1'b1, 3'd1, 9'b010_100_000, 7'h17})
      $display("FAIL bag_seed_const got %h exp %h", {valid, piece, preview, bag_used}, {1'b1, 3'd1, 9'b010_100_000, 7'h17});
    else passed++;
  endtask

  task automatic test_bag_fairness();
    int got[$];
    int seen;
    mode = 1;
    seed = 16'($urandom_range(1, 65535));
    seed_load = 1;
    tick();
    seed_load = 0;
    for (int i = 0; i < 3000 && got.size() < 14; i++) begin
      take = valid;
      if (valid) got.push_back(int'(piece));
      tick();
      total++;
      if ({valid, piece, preview, bag_used} !== exp_out()) $display("FAIL fair_cyc%0d got %h exp %h", i, {valid, piece, preview, bag_used}, exp_out());
      else passed++;
    end
    take = 0;
    total++;
    if (got.size() != 14) $display("FAIL fair_timeout got %0d pieces exp 14", got.size());
    else begin
      passed++;
      for (int g = 0; g < 2; g++) begin
        seen = 0;
        for (int k = 0; k < 7; k++) seen |= 1 << got[g*7+k];
        total++;
        if (seen != 'h7F) $display("FAIL fair_perm%0d got %h exp 7f", g, seen);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = 0;
    seed = 16'($urandom_range(1, 65535));
    seed_load = 1;
    tick();
    seed_load = 0;
    for (int i = 0; i < 40 && !valid; i++) tick();
    take = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({valid, piece, preview, bag_used} !== exp_out()) $display("FAIL take_hold_cyc%0d got %h exp %h", i, {valid, piece, preview, bag_used}, exp_out());
      else passed++;
    end
    take = 0;
    seed_load = 1;
    tick();
    seed_load = 0;
    take = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid !== 1'b0 || {valid, piece, preview, bag_used} !== exp_out()) $display("FAIL take_invalid_cyc%0d got %h exp %h", i, {valid, piece, preview, bag_used}, exp_out());
      else passed++;
    end
    take = 0;
  endtask

  task automatic test_zero_seed_and_async_reset();
    mode = 0;
    seed = 16'h0000;
    seed_load = 1;
    tick();
    seed_load = 0;
    tick();
    total++;
    if (piece !== 3'd1 || {valid, piece, preview, bag_used} !== exp_out()) $display("FAIL zero_seed got %h exp %h", {valid, piece, preview, bag_used}, exp_out());
    else passed++;
    tick();
    #2;
    reset = 1;
    #1;
    model_reset();
    total++;
    if ({valid, piece, preview, bag_used} !== 20'h0) $display("FAIL async_reset got %h exp 00000", {valid, piece, preview, bag_used});
    else passed++;
    tick();
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({valid, piece, preview, bag_used} !== exp_out()) $display("FAIL after_reset_cyc%0d got %h exp %h", i, {valid, piece, preview, bag_used}, exp_out());
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      take = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      seed_load = $urandom_range(0, 59) == 0;
      seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
      total++;
      if ({valid, piece, preview, bag_used} !== exp_out()) $display("FAIL random_cyc%0d got %h exp %h", i, {valid, piece, preview, bag_used}, exp_out());
      else passed++;
    end
    seed_load = 0;
    take = 0;
  endtask

  initial begin
    test_reset();
    test_seed_one();
    test_bag_seed();
    test_bag_fairness();
    test_back_to_back();
    test_zero_seed_and_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
